// File: rtl/xrv_pkg.sv
// Shared definitions for the xrv data-bus arbiter.
//   bus_state_t : arbiter FSM states (IDLE, GNT0, GNT1)
//   ERR_DATA    : read data returned to a master whose transfer timed out
//   CNT_W       : width of the grant wait counter
//   rr_pick     : two-way round-robin choice given the request vector and
//                 the previously granted master
package xrv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } bus_state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          CNT_W    = 16;

  // A lone requester always wins; on a tie the master that was not granted
  // last time wins. Returns the index of the winning master.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    if (req == 2'b11) begin
      return ~last_grant;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/xrv_rr_arb2.sv
// Two-way round-robin grant logic with its last-grant memory.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   req[1:0]   : per-master request (bit 0 = m0, bit 1 = m1)
//   en         : arbitration allowed this cycle (bus idle)
//   gnt_valid  : a grant is issued this cycle
//   gnt_idx    : index of the granted master, valid with gnt_valid
module xrv_rr_arb2
  import xrv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant;

  assign gnt_valid = en & (|req);
  assign gnt_idx   = rr_pick(req, last_grant);

  // Remember who won the most recent grant so the next tie goes to the
  // other master. Resetting to 1 lets m0 win the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt_valid) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/xrv_dbus_arb.sv
// Two-master to one-slave data-bus arbiter.
// Ports:
//   clk, rstb                  : clock and asynchronous active-high reset
//   m0_* / m1_*                : master request side (addr, be, wr_data,
//                                wr_req, rd_req in; wr_ready, rd_ready,
//                                rd_data out)
//   s_addr/s_be/s_wr_data      : registered slave request fields
//   s_wr_req/s_rd_req          : registered slave requests
//   s_wr_ready/s_rd_ready/s_rd_data : slave completion and read data
//   bus_err                    : one-cycle pulse when a transfer times out
//   busy                       : a transfer is in progress
module xrv_dbus_arb
  import xrv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] m0_addr,
  input  logic        m0_wr_req,
  input  logic        m0_rd_req,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wr_data,
  output logic        m0_wr_ready,
  output logic        m0_rd_ready,
  output logic [31:0] m0_rd_data,
  input  logic [31:0] m1_addr,
  input  logic        m1_wr_req,
  input  logic        m1_rd_req,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wr_data,
  output logic        m1_wr_ready,
  output logic        m1_rd_ready,
  output logic [31:0] m1_rd_data,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic [31:0] s_wr_data,
  output logic        s_wr_req,
  output logic        s_rd_req,
  input  logic        s_wr_ready,
  input  logic        s_rd_ready,
  input  logic [31:0] s_rd_data,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  bus_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  req_any;
  logic        arb_en, gnt_valid, gnt_idx;
  logic        sel_wr;
  logic [31:0] sel_addr, sel_wr_data;
  logic [3:0]  sel_be;
  logic        in_xfer, slave_done, to_hit, xfer_end;
  logic        xfer_wr_ready, xfer_rd_ready;
  logic [31:0] xfer_rd_data;

  assign req_any = {m1_wr_req | m1_rd_req, m0_wr_req | m0_rd_req};
  assign arb_en  = (state == IDLE);

  xrv_rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rstb),
    .req       (req_any),
    .en        (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Fields of the winning master. A master asking for both a write and a
  // read gets the write first; its held read wins a later grant.
  assign sel_wr      = gnt_idx ? m1_wr_req  : m0_wr_req;
  assign sel_addr    = gnt_idx ? m1_addr    : m0_addr;
  assign sel_be      = gnt_idx ? m1_be      : m0_be;
  assign sel_wr_data = gnt_idx ? m1_wr_data : m0_wr_data;

  // Slave readiness only counts for the request type actually pending;
  // s_*_req are low in IDLE, so idle readies are ignored as well.
  assign in_xfer    = (state != IDLE);
  assign slave_done = (s_wr_req & s_wr_ready) | (s_rd_req & s_rd_ready);
  assign to_hit     = in_xfer & (cnt == TO_LIMIT) & ~slave_done;
  assign xfer_end   = in_xfer & (slave_done | to_hit);

  assign xfer_wr_ready = s_wr_req & (s_wr_ready | to_hit);
  assign xfer_rd_ready = s_rd_req & (s_rd_ready | to_hit);
  assign xfer_rd_data  = to_hit ? ERR_DATA : s_rd_data;

  // State register: reset drops any transfer in flight back to IDLE.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant from IDLE, return to IDLE on completion or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_next = gnt_idx ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        if (xfer_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave request registers and the grant wait counter. Fields are captured
  // on the grant edge so the slave sees them one cycle after the request;
  // the counter restarts on every grant and holds zero while idle.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      cnt       <= '0;
      s_addr    <= '0;
      s_be      <= '0;
      s_wr_data <= '0;
      s_wr_req  <= 1'b0;
      s_rd_req  <= 1'b0;
    end else if (arb_en && gnt_valid) begin
      s_addr    <= sel_addr;
      s_be      <= sel_be;
      s_wr_data <= sel_wr_data;
      s_wr_req  <= sel_wr;
      s_rd_req  <= ~sel_wr;
      cnt       <= '0;
    end else if (xfer_end) begin
      s_wr_req  <= 1'b0;
      s_rd_req  <= 1'b0;
      cnt       <= '0;
    end else if (in_xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Master-side outputs: only the granted master sees completion and data;
  // the other master is held at zero.
  always_comb begin
    m0_wr_ready = 1'b0;
    m0_rd_ready = 1'b0;
    m0_rd_data  = '0;
    m1_wr_ready = 1'b0;
    m1_rd_ready = 1'b0;
    m1_rd_data  = '0;
    bus_err     = to_hit;
    busy        = in_xfer;
    case (state)
      GNT0: begin
        m0_wr_ready = xfer_wr_ready;
        m0_rd_ready = xfer_rd_ready;
        m0_rd_data  = xfer_rd_data;
      end
      GNT1: begin
        m1_wr_ready = xfer_wr_ready;
        m1_rd_ready = xfer_rd_ready;
        m1_rd_data  = xfer_rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xrv_dbus_arb.sv
// Self-checking bench for xrv_dbus_arb: a table of single transfers, hand
// sequences for arbitration order and reset, and a randomized run checked
// against a transaction-level model of the arbiter.
module tb_xrv_dbus_arb;
  import xrv_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic [31:0] m_addr    [2];
  logic        m_wr_req  [2];
  logic        m_rd_req  [2];
  logic [3:0]  m_be      [2];
  logic [31:0] m_wr_data [2];

  logic        m0_wr_ready, m0_rd_ready, m1_wr_ready, m1_rd_ready;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic [31:0] s_addr, s_wr_data, s_rd_data;
  logic [3:0]  s_be;
  logic        s_wr_req, s_rd_req, s_wr_ready, s_rd_ready, bus_err, busy;

  logic [1:0]  wr_rdy, rd_rdy;
  logic [31:0] rd_dat [2];
  assign wr_rdy    = {m1_wr_ready, m0_wr_ready};
  assign rd_rdy    = {m1_rd_ready, m0_rd_ready};
  assign rd_dat[0] = m0_rd_data;
  assign rd_dat[1] = m1_rd_data;

  xrv_dbus_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb),
    .m0_addr(m_addr[0]), .m0_wr_req(m_wr_req[0]), .m0_rd_req(m_rd_req[0]),
    .m0_be(m_be[0]), .m0_wr_data(m_wr_data[0]),
    .m0_wr_ready(m0_wr_ready), .m0_rd_ready(m0_rd_ready), .m0_rd_data(m0_rd_data),
    .m1_addr(m_addr[1]), .m1_wr_req(m_wr_req[1]), .m1_rd_req(m_rd_req[1]),
    .m1_be(m_be[1]), .m1_wr_data(m_wr_data[1]),
    .m1_wr_ready(m1_wr_ready), .m1_rd_ready(m1_rd_ready), .m1_rd_data(m1_rd_data),
    .s_addr(s_addr), .s_be(s_be), .s_wr_data(s_wr_data),
    .s_wr_req(s_wr_req), .s_rd_req(s_rd_req),
    .s_wr_ready(s_wr_ready), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data),
    .bus_err(bus_err), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          master;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] sdata;
    int          exp_k;
    logic [31:0] exp_data;
    bit          chk_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one master's request lines.
  task automatic applyStimulus(input int m, input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data);
    m_wr_req[m]  = wr;
    m_rd_req[m]  = rd;
    m_addr[m]    = addr;
    m_be[m]      = be;
    m_wr_data[m] = data;
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    s_wr_ready = 1'b0;
    s_rd_ready = 1'b0;
    s_rd_data  = 32'h0;
  endtask

  task automatic doReset();
    rstb = 1'b1;
    clearInputs();
    tick();
    tick();
    rstb = 1'b0;
    tick();
  endtask

  // Runs one table record as a single-master transfer and compares its
  // grant fields, completion cycle, data and error against the record.
  task automatic runVector(input vec_t v);
    int          got_k;
    logic [31:0] got_data;
    bit          got_err, noise;
    int          o;
    got_k = -1; got_data = '0; got_err = 1'b0; noise = 1'b0;
    o = 1 - v.master;
    s_rd_data = v.sdata;
    applyStimulus(v.master, v.wr, !v.wr, v.addr, v.be, v.wdata);
    for (int k = 0; k < 10 && got_k < 0; k++) begin
      tick();
      if (k == 0) begin
        checkOutput("vec s_addr", s_addr, v.addr);
        checkOutput("vec s_ctl", {s_be, s_wr_req, s_rd_req, busy}, {v.be, v.wr, !v.wr, 1'b1});
        checkOutput("vec s_wr_data", s_wr_data, v.wdata);
      end
      s_wr_ready = v.wr && (k == v.lat);
      s_rd_ready = !v.wr && (k == v.lat);
      @(negedge clk);
      if (wr_rdy[o] || rd_rdy[o] || rd_dat[o] != 32'h0) noise = 1'b1;
      if (v.wr ? wr_rdy[v.master] : rd_rdy[v.master]) begin
        got_k    = k;
        got_data = rd_dat[v.master];
        got_err  = bus_err;
      end else if (bus_err) begin
        noise = 1'b1;
      end
    end
    checkOutput("vec ready cycle", 64'(got_k), 64'(v.exp_k));
    checkOutput("vec bus_err", got_err, v.exp_err);
    if (v.chk_data) checkOutput("vec rd_data", got_data, v.exp_data);
    checkOutput("vec other quiet", noise, 1'b0);
    tick();
    clearInputs();
    checkOutput("vec idle after", {busy, s_wr_req, s_rd_req}, 3'b000);
    tick();
  endtask

  // Randomized run against a transaction-level model: who should own the
  // bus, what it should present to the slave, and when each master must
  // see completion, data or an error.
  task automatic runRandom(input int cycles);
    bit          mb, mwr, end_prev, starting, done, tmo;
    int          own, mk, mlat, last, r;
    logic        p_wr [2];
    logic        p_rd [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    logic [3:0]  p_be [2];
    logic [31:0] ed [2];
    bit          any0, any1;
    mb = 0; mwr = 0; end_prev = 0; own = 0; mk = 0; mlat = 0; last = 1;
    for (int i = 0; i < 2; i++) begin
      p_wr[i] = 0; p_rd[i] = 0; p_addr[i] = 0; p_data[i] = 0; p_be[i] = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      tick();
      starting = 0;
      any0 = p_wr[0] | p_rd[0];
      any1 = p_wr[1] | p_rd[1];
      if (mb) begin
        if (end_prev) mb = 0;
        else mk++;
      end else if (any0 || any1) begin
        own = (any0 && any1) ? 1 - last : (any0 ? 0 : 1);
        last = own;
        mwr = p_wr[own];
        mb = 1; mk = 0; mlat = $urandom_range(0, 6);
        starting = 1;
      end
      checkOutput("rnd slave req", {s_wr_req, s_rd_req}, {mb && mwr, mb && !mwr});
      if (starting) begin
        checkOutput("rnd s_addr", s_addr, p_addr[own]);
        checkOutput("rnd s_be_data", {s_be, s_wr_data}, {p_be[own], p_data[own]});
      end
      s_wr_ready = (mb && mwr)  ? (mk == mlat) : ($urandom_range(0, 3) == 0);
      s_rd_ready = (mb && !mwr) ? (mk == mlat) : ($urandom_range(0, 3) == 0);
      s_rd_data  = $urandom;
      for (int x = 0; x < 2; x++) begin
        if (!m_wr_req[x] && !m_rd_req[x] && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 2);
          applyStimulus(x, r != 1, r != 0, {1'(x), 31'($urandom)}, 4'($urandom), $urandom);
        end
        p_wr[x] = m_wr_req[x]; p_rd[x] = m_rd_req[x];
        p_addr[x] = m_addr[x]; p_be[x] = m_be[x]; p_data[x] = m_wr_data[x];
      end
      @(negedge clk);
      done = mb && ((mk == mlat) || (mk == TO));
      tmo  = mb && (mk == TO) && (mk != mlat);
      for (int x = 0; x < 2; x++) begin
        ed[x] = (mb && own == x) ? (tmo ? 32'hDEAD_BEEF : s_rd_data) : 32'h0;
      end
      checkOutput("rnd readies",
        {m1_wr_ready, m1_rd_ready, m0_wr_ready, m0_rd_ready, bus_err, busy},
        {done && own == 1 && mwr, done && own == 1 && !mwr,
         done && own == 0 && mwr, done && own == 0 && !mwr, tmo, mb});
      checkOutput("rnd m0_rd_data", m0_rd_data, ed[0]);
      checkOutput("rnd m1_rd_data", m1_rd_data, ed[1]);
      end_prev = done;
      if (done) begin
        if (mwr) m_wr_req[own] = 1'b0;
        else     m_rd_req[own] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0100, 4'hF, 32'h0,         3,  32'h1234_5678, 3, 32'h1234_5678, 1, 0};
    vecs[1] = '{1, 0, 32'h8000_0200, 4'hF, 32'h0,         99, 32'h0BAD_0BAD, 4, 32'hDEAD_BEEF, 1, 1};
    vecs[2] = '{0, 1, 32'h0000_0104, 4'h3, 32'hAABB_CCDD, 0,  32'h0000_0077, 0, 32'h0,         0, 0};
    vecs[3] = '{1, 1, 32'h8000_0208, 4'hC, 32'h0102_0304, 4,  32'h0,         4, 32'h0,         0, 0};
    vecs[4] = '{0, 0, 32'h0000_010C, 4'hF, 32'h0,         4,  32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1, 0};
    vecs[5] = '{1, 1, 32'h8000_0210, 4'h1, 32'h0000_0009, 7,  32'h0000_0003, 4, 32'hDEAD_BEEF, 1, 1};
    vecs[6] = '{1, 0, 32'h8000_0214, 4'h6, 32'h0,         1,  32'h0000_0001, 1, 32'h0000_0001, 1, 0};

    rstb = 1'b1;
    clearInputs();
    #1;
    checkOutput("reset state", {s_wr_req, s_rd_req, busy, bus_err, s_be}, 8'h00);
    checkOutput("reset s_addr/data", {s_addr, s_wr_data}, 64'h0);
    doReset();

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    $display("[TB] simultaneous writes after reset");
    doReset();
    applyStimulus(0, 1, 0, 32'h0000_0010, 4'h3, 32'h1111_1111);
    applyStimulus(1, 1, 0, 32'h8000_0020, 4'hC, 32'h2222_2222);
    tick();
    checkOutput("tie first addr", s_addr, 32'h0000_0010);
    checkOutput("tie first be/data", {s_be, s_wr_data, s_wr_req}, {4'h3, 32'h1111_1111, 1'b1});
    s_wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("tie m0 ready", {m0_wr_ready, m1_wr_ready}, 2'b10);
    tick();
    s_wr_ready = 1'b0;
    m_wr_req[0] = 1'b0;
    checkOutput("tie gap idle", {busy, s_wr_req}, 2'b00);
    tick();
    checkOutput("tie second addr", s_addr, 32'h8000_0020);
    checkOutput("tie second be/data", {s_be, s_wr_data, s_wr_req}, {4'hC, 32'h2222_2222, 1'b1});
    s_wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("tie m1 ready", {m0_wr_ready, m1_wr_ready}, 2'b01);
    tick();
    clearInputs();
    tick();

    $display("[TB] alternating grants");
    doReset();
    applyStimulus(0, 1, 0, 32'h0000_0030, 4'hF, 32'h3);
    applyStimulus(1, 1, 0, 32'h8000_0030, 4'hF, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("alt grant owner", {s_wr_req, s_addr[31]}, {1'b1, 1'(i % 2)});
      s_wr_ready = 1'b1;
      tick();
      s_wr_ready = 1'b0;
    end
    clearInputs();
    tick();

    $display("[TB] reset during transfer");
    doReset();
    applyStimulus(1, 1, 0, 32'h8000_0040, 4'hF, 32'h5555_AAAA);
    tick();
    checkOutput("rst pre grant", {s_wr_req, busy}, 2'b11);
    tick();
    rstb = 1'b1;
    #1;
    checkOutput("rst async clear", {s_wr_req, busy, s_addr}, {2'b00, 32'h0});
    s_wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst no ready", {m1_wr_ready, m0_wr_ready, bus_err}, 3'b000);
    tick();
    rstb = 1'b0;
    s_wr_ready = 1'b0;
    tick();
    checkOutput("rst regrant", {s_wr_req, s_addr}, {1'b1, 32'h8000_0040});
    s_wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst served", {m1_wr_ready, m1_rd_ready}, 2'b10);
    tick();
    clearInputs();
    s_wr_ready = 1'b1;
    s_rd_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle slave ready ignored",
      {m0_wr_ready, m0_rd_ready, m1_wr_ready, m1_rd_ready, busy}, 5'b00000);
    tick();
    clearInputs();

    $display("[TB] randomized run");
    doReset();
    runRandom(3000);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xrv_dbus_arb.md
XRV_DBUS_ARB -- requirements
Module: xrv_dbus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 2..65535: maximum cycles a granted transfer waits for slave ready.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstb, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_addr/m1_addr, input, 32: master byte address.
REQ-005 SHALL have ports m0_wr_req/m1_wr_req, input, 1: write request, held high until its wr_ready.
REQ-006 SHALL have ports m0_rd_req/m1_rd_req, input, 1: read request, held high until its rd_ready.
REQ-007 SHALL have ports m0_be/m1_be, input, 4: byte enables.
REQ-008 SHALL have ports m0_wr_data/m1_wr_data, input, 32: write data.
REQ-009 SHALL have ports m0_wr_ready/m1_wr_ready, output, 1: write completion pulse.
REQ-010 SHALL have ports m0_rd_ready/m1_rd_ready, output, 1: read completion pulse.
REQ-011 SHALL have ports m0_rd_data/m1_rd_data, output, 32: read data, valid with rd_ready.
REQ-012 SHALL have ports s_addr, s_be and s_wr_data, output, 32/4/32: slave request fields, registered.
REQ-013 SHALL have ports s_wr_req and s_rd_req, output, 1: slave requests, registered.
REQ-014 SHALL have ports s_wr_ready and s_rd_ready, input, 1; s_rd_data, input, 32: slave completion and read data.
REQ-015 SHALL have port bus_err, output, 1: one-cycle pulse on timeout.
REQ-016 SHALL have port busy, output, 1: high when state is not IDLE.

Function
REQ-017 SHALL use FSM states IDLE, GNT0 and GNT1, plus a 1-bit last_grant register.
REQ-018 In IDLE with any m*_wr_req|m*_rd_req: SHALL move to GNT0 or GNT1 next cycle, registering addr/be/wr_data and setting s_wr_req or s_rd_req (request-to-slave latency 1 cycle).
REQ-019 When both masters request in the same IDLE cycle: SHALL grant the master not equal to last_grant; last_grant SHALL update on every grant.
REQ-020 When one master asserts wr_req and rd_req together: SHALL serve the write first; the read is served by a later grant.
REQ-021 While GNTx: m_x_wr_ready SHALL equal s_wr_ready & s_wr_req, and m_x_rd_ready SHALL equal s_rd_ready & s_rd_req, both combinational; m_x_rd_data SHALL equal s_rd_data.
REQ-022 The non-granted master's ready outputs SHALL be 0 and its rd_data SHALL be 32'h0.
REQ-023 On a slave ready cycle: SHALL clear s_*_req and return to IDLE at the next edge; a new grant SHALL occur no earlier than 2 cycles after the ready cycle.
REQ-024 SHALL count cycles in GNTx with a 16-bit counter that clears on grant; when it reaches TIMEOUT_CYCLES with no slave ready, SHALL for one cycle:
- pulse m_x ready (wr or rd, per the pending type) with m_x_rd_data=32'hDEAD_BEEF;
- pulse bus_err;
- clear s_*_req;
- return to IDLE.
REQ-025 Slave ready in the same cycle as a timeout: SHALL treat the transfer as a normal completion, with no bus_err and real data.
REQ-026 Slave ready while in IDLE, or for the request type not pending: SHALL be ignored and SHALL NOT propagate to any master.
REQ-027 Master requests SHALL NOT be sampled while GNTx; a request dropped before grant is lost silently.

Reset
REQ-028 rstb high SHALL asynchronously force: state=IDLE, last_grant=1 (m0 wins first tie), counter=0, s_wr_req=s_rd_req=0, s_addr=s_wr_data=0, s_be=0, bus_err=0, busy=0.
REQ-029 Reset mid-transfer SHALL abandon the slave transfer; no master ready SHALL be issued for it.

Structure
REQ-030 SHALL take the state enum (IDLE/GNT0/GNT1) and the 32'hDEAD_BEEF error-data constant from the shared package xrv_pkg.
REQ-031 SHALL place the 2-way round-robin grant logic plus last_grant in sub-module xrv_rr_arb2; all else stays in xrv_dbus_arb.

Verification
REQ-032 m0 read of 0x100, slave ready 3 cycles after s_rd_req with data 0x12345678 -> m0_rd_ready one cycle, m0_rd_data=0x12345678, m1 outputs 0.
REQ-033 m0 and m1 write in the same cycle after reset -> m0 granted first, m1 granted 2 cycles after m0's ready; s_be/s_wr_data match each master.
REQ-034 Back-to-back simultaneous requests ×4 -> grants alternate m0,m1,m0,m1.
REQ-035 TIMEOUT_CYCLES=4, slave never ready -> after 4 grant cycles, m1_rd_ready=1, m1_rd_data=0xDEADBEEF, bus_err=1 for one cycle, state IDLE.
REQ-036 rstb asserted while GNT1 with a write pending -> s_wr_req=0 immediately, no m1_wr_ready, busy=0; next m1 request served normally.
